// File: rtl/hazard_detection_unit_pkg.sv
// hazard_pkg: op-type and forward-select encodings shared by hazard and decode logic.
package hazard_pkg;
    localparam logic [1:0] OPT_NONE  = 2'b00;
    localparam logic [1:0] OPT_ALU   = 2'b01;
    localparam logic [1:0] OPT_LOAD  = 2'b10;
    localparam logic [1:0] OPT_STORE = 2'b11;
    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EXE_ALU = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;
    // A load still in EXE has no data yet; the stall covers it, so read the regfile.
    function automatic logic [1:0] fwd_sel(input logic [1:0] opt_exe, input logic [1:0] opt_mem,
                                           input logic m_exe, input logic m_mem);
        return (opt_exe == OPT_LOAD && m_exe) ? FWD_RF :
               (opt_exe == OPT_ALU && m_exe)  ? FWD_EXE_ALU :
               (opt_mem == OPT_ALU && m_mem)  ? FWD_MEM_ALU :
               (opt_mem == OPT_LOAD && m_mem) ? FWD_MEM_LD : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: pipeline control/index inputs and hazard control outputs.
interface hazard_detection_unit_if #(parameter int CNT_W = 32);
    logic             rs1use_ID;
    logic             rs2use_ID;
    logic [1:0]       hazard_optype_ID;
    logic             Branch_ID;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_EXE;
    logic [4:0]       rd_MEM;
    logic [4:0]       rs2_EXE;
    logic             PC_EN_IF;
    logic             reg_FD_EN;
    logic             reg_FD_flush;
    logic             reg_DE_EN;
    logic             reg_DE_flush;
    logic             reg_EM_EN;
    logic             reg_EM_flush;
    logic             reg_MW_EN;
    logic [1:0]       forward_ctrl_A;
    logic [1:0]       forward_ctrl_B;
    logic             forward_ctrl_ls;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID, rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE,
        input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush,
               reg_MW_EN, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, stall_cnt, flush_cnt
    );
    modport slave (
        input  rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID, rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE,
        output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush,
               reg_MW_EN, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int W = 32) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = (inc && !(&q_q)) ? q_q + W'(1) : q_q;
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: forwarding selects, load-use stall and branch flush for a 5-stage pipeline.
module hazard_detection_unit import hazard_pkg::*; #(parameter int CNT_W = 32) (
    input logic                  clk,
    input logic                  rst,
    hazard_detection_unit_if.slave hif
);
    logic [1:0]       optype_exe_q, optype_exe_d, optype_mem_q, optype_mem_d;
    logic             m_exe_a, m_exe_b, m_mem_a, m_mem_b, stall, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    always_comb begin
        m_exe_a = hif.rd_EXE != 5'd0 && hif.rd_EXE == hif.rs1_ID && hif.rs1use_ID;
        m_exe_b = hif.rd_EXE != 5'd0 && hif.rd_EXE == hif.rs2_ID && hif.rs2use_ID;
        m_mem_a = hif.rd_MEM != 5'd0 && hif.rd_MEM == hif.rs1_ID && hif.rs1use_ID;
        m_mem_b = hif.rd_MEM != 5'd0 && hif.rd_MEM == hif.rs2_ID && hif.rs2use_ID;
        // Store data on rs2 is picked up from MEM one cycle later instead of stalling.
        stall = optype_exe_q == OPT_LOAD && (m_exe_a || (m_exe_b && hif.hazard_optype_ID != OPT_STORE));
        flush = hif.Branch_ID && !stall;
        optype_exe_d = stall ? OPT_NONE : hif.hazard_optype_ID;
        optype_mem_d = optype_exe_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            optype_exe_q <= OPT_NONE;
            optype_mem_q <= OPT_NONE;
        end else begin
            optype_exe_q <= optype_exe_d;
            optype_mem_q <= optype_mem_d;
        end
    end
    assign hif.forward_ctrl_A  = fwd_sel(optype_exe_q, optype_mem_q, m_exe_a, m_mem_a);
    assign hif.forward_ctrl_B  = fwd_sel(optype_exe_q, optype_mem_q, m_exe_b, m_mem_b);
    assign hif.forward_ctrl_ls = optype_mem_q == OPT_LOAD && hif.rd_MEM != 5'd0 &&
                                 hif.rd_MEM == hif.rs2_EXE && optype_exe_q == OPT_STORE;
    assign hif.PC_EN_IF     = !stall;
    assign hif.reg_FD_EN    = !stall;
    assign hif.reg_FD_flush = flush;
    assign hif.reg_DE_EN    = 1'b1;
    assign hif.reg_DE_flush = stall;
    assign hif.reg_EM_EN    = 1'b1;
    assign hif.reg_EM_flush = 1'b0;
    assign hif.reg_MW_EN    = 1'b1;
    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall), .q(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush), .q(flush_cnt));
    assign hif.stall_cnt = stall_cnt;
    assign hif.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: vector table with expected-result queue plus reset/saturation sequences.
module tb_hazard_detection_unit;
    import hazard_pkg::*;
    localparam int CNT_W = 4;
    typedef struct {
        logic [1:0] opt;
        logic       u1, u2;
        logic [4:0] r1, r2;
        logic       br;
        logic [4:0] rde, rdm, r2e;
        logic [1:0] fa, fb;
        logic       fls, st, ffl;
        int         sc, fc;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    vec_t vecs[14];
    vec_t exp_q[$];
    hazard_detection_unit_if #(.CNT_W(CNT_W)) hif();
    hazard_detection_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hif(hif.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic [1:0] opt, input logic u1, input logic u2, input logic [4:0] r1,
                         input logic [4:0] r2, input logic br, input logic [4:0] rde,
                         input logic [4:0] rdm, input logic [4:0] r2e);
        hif.hazard_optype_ID = opt;
        hif.rs1use_ID = u1;
        hif.rs2use_ID = u2;
        hif.rs1_ID = r1;
        hif.rs2_ID = r2;
        hif.Branch_ID = br;
        hif.rd_EXE = rde;
        hif.rd_MEM = rdm;
        hif.rs2_EXE = r2e;
    endtask
    function automatic logic [7:0] ctrl_now();
        return {hif.PC_EN_IF, hif.reg_FD_EN, hif.reg_FD_flush, hif.reg_DE_EN,
                hif.reg_DE_flush, hif.reg_EM_EN, hif.reg_EM_flush, hif.reg_MW_EN};
    endfunction
    function automatic logic [7:0] ctrl_exp(input logic st, input logic ffl);
        return {!st, !st, ffl, 1'b1, st, 1'b1, 1'b0, 1'b1};
    endfunction
    initial begin
        //          opt        u1 u2 r1 r2 br rde rdm r2e  fa     fb     ls st ffl sc fc
        vecs[0]  = '{OPT_ALU,   0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0};
        vecs[1]  = '{OPT_ALU,   1, 1, 5, 6, 0, 5, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0};
        vecs[2]  = '{OPT_LOAD,  1, 1, 0, 9, 0, 0, 9, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0};
        vecs[3]  = '{OPT_ALU,   1, 1, 1, 7, 1, 7, 1, 0, 2'b10, 2'b00, 0, 1, 0, 0, 0};
        vecs[4]  = '{OPT_ALU,   1, 1, 1, 7, 1, 1, 7, 0, 2'b00, 2'b11, 0, 0, 1, 1, 0};
        vecs[5]  = '{OPT_LOAD,  1, 0, 3, 3, 0, 3, 3, 0, 2'b01, 2'b00, 0, 0, 0, 1, 1};
        vecs[6]  = '{OPT_STORE, 1, 1, 2, 7, 0, 7, 7, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1};
        vecs[7]  = '{OPT_NONE,  0, 0, 7, 0, 0, 0, 7, 7, 2'b00, 2'b00, 1, 0, 0, 1, 1};
        vecs[8]  = '{OPT_ALU,   1, 0, 7, 0, 0, 0, 7, 7, 2'b00, 2'b00, 0, 0, 0, 1, 1};
        vecs[9]  = '{OPT_NONE,  0, 1, 5, 5, 1, 5, 0, 0, 2'b00, 2'b01, 0, 0, 1, 1, 1};
        vecs[10] = '{OPT_LOAD,  1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2};
        vecs[11] = '{OPT_STORE, 1, 1, 8, 8, 0, 8, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 2};
        vecs[12] = '{OPT_ALU,   1, 0, 8, 0, 0, 0, 8, 0, 2'b11, 2'b00, 0, 0, 0, 2, 2};
        vecs[13] = '{OPT_NONE,  1, 0, 3, 0, 0, 3, 3, 0, 2'b01, 2'b00, 0, 0, 0, 2, 2};
        drive(OPT_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall_cnt", 32'(hif.stall_cnt), 0);
        chk("reset flush_cnt", 32'(hif.flush_cnt), 0);
        chk("reset ctrl", 32'(ctrl_now()), 32'(ctrl_exp(0, 0)));
        chk("reset fa", 32'(hif.forward_ctrl_A), 0);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            vec_t v, e;
            @(posedge clk);
            #1;
            v = vecs[i];
            drive(v.opt, v.u1, v.u2, v.r1, v.r2, v.br, v.rde, v.rdm, v.r2e);
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("row%0d fwd_A", i), 32'(hif.forward_ctrl_A), 32'(e.fa));
            chk($sformatf("row%0d fwd_B", i), 32'(hif.forward_ctrl_B), 32'(e.fb));
            chk($sformatf("row%0d fwd_ls", i), 32'(hif.forward_ctrl_ls), 32'(e.fls));
            chk($sformatf("row%0d ctrl", i), 32'(ctrl_now()), 32'(ctrl_exp(e.st, e.ffl)));
            chk($sformatf("row%0d stall_cnt", i), 32'(hif.stall_cnt), 32'(e.sc));
            chk($sformatf("row%0d flush_cnt", i), 32'(hif.flush_cnt), 32'(e.fc));
        end
        // reset asserted while a load-use stall is active
        @(posedge clk);
        #1;
        drive(OPT_LOAD, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(OPT_ALU, 1, 0, 7, 0, 1, 7, 0, 0);
        @(negedge clk);
        chk("pre-reset stall", 32'(ctrl_now()), 32'(ctrl_exp(1, 0)));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset stall", 32'(hif.PC_EN_IF), 1);
        chk("post-reset stall_cnt", 32'(hif.stall_cnt), 0);
        chk("post-reset flush_cnt", 32'(hif.flush_cnt), 0);
        // constant inputs alternate flush and stall cycles: 20 of each
        rst = 1'b0;
        drive(OPT_LOAD, 1, 0, 7, 0, 1, 7, 0, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("sat cyc%0d ctrl", k), 32'(ctrl_now()), 32'(ctrl_exp(k % 2 == 1, k % 2 == 0)));
            @(posedge clk);
            #1;
            if (k == 19) begin
                chk("mid stall_cnt", 32'(hif.stall_cnt), 10);
                chk("mid flush_cnt", 32'(hif.flush_cnt), 10);
            end
        end
        chk("sat stall_cnt", 32'(hif.stall_cnt), 15);
        chk("sat flush_cnt", 32'(hif.flush_cnt), 15);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
